// File: rtl/led_seq_pkg.sv
// Shared types and pure helpers for the LED sequencer: pattern modes,
// per-mode period length and the per-LED decode.
package led_seq_pkg;

    typedef enum logic [1:0] {
        JOHNSON = 2'b00,
        BOUNCE  = 2'b01,
        RING    = 2'b10,
        BAR     = 2'b11
    } mode_t;

    function automatic int unsigned period(input mode_t mode, input int unsigned width);
        int unsigned p;
        case (mode)
            JOHNSON: p = 2 * width;
            BOUNCE:  p = 2 * width - 2;
            default: p = width;
        endcase
        return p;
    endfunction

    // Decides whether LED idx is lit for a given mode and phase.
    function automatic logic led_on(input mode_t mode, input int unsigned ph,
                                    input int unsigned idx, input int unsigned width);
        logic on;
        on = 1'b0;
        case (mode)
            JOHNSON: on = (ph < width) ? (idx < ph) : (idx >= ph - width);
            BOUNCE:  on = (ph < width) ? (idx == ph) : (idx == 2 * width - 2 - ph);
            RING:    on = (idx == ph);
            BAR:     on = (idx <= ph);
            default: on = 1'b0;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Free-running step prescaler: TC pulses once every PRESCALE enabled cycles;
// CLR restarts the count and suppresses the pulse on that cycle.
module step_prescaler #(
    parameter int PRESCALE = 1250000
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic ENABLE,
    input  logic CLR,
    output logic TC
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] PC_LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pc;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            pc <= '0;
        end else if (CLR) begin
            pc <= '0;
        end else if (ENABLE) begin
            pc <= (pc == PC_LAST) ? '0 : pc + CW'(1);
        end
    end

    // RSTn gating keeps TC low in reset even when PRESCALE is 1.
    assign TC = RSTn && ENABLE && !CLR && (pc == PC_LAST);

endmodule

// File: rtl/led_sequencer.sv
// WIDTH-LED pattern generator: prescaled phase counter with direction control,
// four run-time patterns and a wrap pulse at the end of each pattern period.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1250000
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             ENABLE,
    input  logic [1:0]       MODE,
    input  logic             DIR,
    output logic [WIDTH-1:0] LEDS,
    output logic             STEP,
    output logic             WRAP
);

    localparam int PHW = $clog2(2 * WIDTH);

    mode_t          mode_q;
    logic           mode_chg;
    logic           step;
    logic           wrap;
    logic [PHW-1:0] ph;
    logic [PHW-1:0] ph_last;
    logic [PHW-1:0] ph_next;

    assign mode_chg = (mode_t'(MODE) != mode_q);

    step_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .ENABLE(ENABLE),
        .CLR   (mode_chg),
        .TC    (step)
    );

    always_comb begin
        ph_last = PHW'(period(mode_q, WIDTH) - 32'd1);
        ph_next = ph;
        wrap    = 1'b0;
        if (step) begin
            if (DIR) begin
                if (ph == '0) begin
                    ph_next = ph_last;
                    wrap    = 1'b1;
                end else begin
                    ph_next = ph - PHW'(1);
                end
            end else begin
                if (ph == ph_last) begin
                    ph_next = '0;
                    wrap    = 1'b1;
                end else begin
                    ph_next = ph + PHW'(1);
                end
            end
        end
    end

    // A mode change restarts the new pattern at phase 0 so PH stays in range.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mode_q <= JOHNSON;
            ph     <= '0;
        end else begin
            mode_q <= mode_t'(MODE);
            ph     <= mode_chg ? '0 : ph_next;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_leds
        assign LEDS[i] = led_on(mode_q, 32'(ph), i, WIDTH);
    end

    assign STEP = step;
    assign WRAP = wrap;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: an 8-LED/prescale-4 instance and a 2-LED/prescale-1
// instance, checked cycle by cycle against a queued reference.
module tb_led_sequencer;

    logic       clk = 1'b0;
    logic       rstn [2];
    logic       en   [2];
    logic       dir  [2];
    logic [1:0] mode [2];

    logic [7:0] leds0;
    logic [1:0] leds1;
    logic       step0, step1, wrap0, wrap1;

    int errors = 0;
    int checks = 0;

    int m_pc   [2];
    int m_ph   [2];
    int m_mode [2];

    typedef struct {
        logic [7:0] leds;
        logic       step;
        logic       wrap;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    led_sequencer #(.WIDTH(8), .PRESCALE(4)) dut0 (
        .CLK(clk), .RSTn(rstn[0]), .ENABLE(en[0]), .MODE(mode[0]), .DIR(dir[0]),
        .LEDS(leds0), .STEP(step0), .WRAP(wrap0)
    );

    led_sequencer #(.WIDTH(2), .PRESCALE(1)) dut1 (
        .CLK(clk), .RSTn(rstn[1]), .ENABLE(en[1]), .MODE(mode[1]), .DIR(dir[1]),
        .LEDS(leds1), .STEP(step1), .WRAP(wrap1)
    );

    function automatic int per(input int m, input int w);
        return (m == 0) ? 2 * w : (m == 1) ? 2 * w - 2 : w;
    endfunction

    // Johnson written as "lit when i < ph <= i+w", bounce as the two mirrored positions.
    function automatic logic [7:0] ref_leds(input int m, input int ph, input int w);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                0:       v[i] = (i < ph) && (ph <= i + w);
                1:       v[i] = (ph == i) || (ph == 2 * w - 2 - i);
                2:       v[i] = (ph == i);
                default: v[i] = (i <= ph);
            endcase
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        m_pc[d]   = 0;
        m_ph[d]   = 0;
        m_mode[d] = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle(input int d);
        int   w, ps, p;
        exp_t e, got;
        logic s;
        w  = (d == 0) ? 8 : 2;
        ps = (d == 0) ? 4 : 1;
        p  = per(m_mode[d], w);
        #1;
        s = rstn[d] && en[d] && (int'(mode[d]) == m_mode[d]) && (m_pc[d] == ps - 1);
        e.step = s;
        e.wrap = s && (dir[d] ? (m_ph[d] == 0) : (m_ph[d] == p - 1));
        e.leds = rstn[d] ? ref_leds(m_mode[d], m_ph[d], w) : 8'h00;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        check($sformatf("leds%0d", d), (d == 0) ? leds0 : {6'b0, leds1}, got.leds);
        check($sformatf("step%0d", d), {7'b0, (d == 0) ? step0 : step1}, {7'b0, got.step});
        check($sformatf("wrap%0d", d), {7'b0, (d == 0) ? wrap0 : wrap1}, {7'b0, got.wrap});
        @(posedge clk);
        if (!rstn[d]) begin
            model_reset(d);
        end else begin
            if (int'(mode[d]) != m_mode[d]) begin
                m_pc[d] = 0;
                m_ph[d] = 0;
            end else if (en[d]) begin
                if (s) begin
                    if (dir[d]) m_ph[d] = (m_ph[d] == 0) ? p - 1 : m_ph[d] - 1;
                    else        m_ph[d] = (m_ph[d] == p - 1) ? 0 : m_ph[d] + 1;
                end
                m_pc[d] = (m_pc[d] + 1) % ps;
            end
            m_mode[d] = int'(mode[d]);
        end
        @(negedge clk);
    endtask

    task automatic run(input int d, input int n);
        for (int i = 0; i < n; i++) cycle(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0;
            en[d]   = 1'b1;
            dir[d]  = 1'b0;
            mode[d] = 2'b00;
            model_reset(d);
        end
        @(negedge clk);
        run(0, 3);
        #1 check("rst_leds", leds0, 8'h00);

        // Johnson, full period plus margin
        rstn[0] = 1'b1;
        run(0, 70);

        // Bounce
        mode[0] = 2'b01;
        run(0, 64);

        // Ring up to 0x04, then down through the wrap
        mode[0] = 2'b10;
        run(0, 9);
        #1 check("ring_at_04", leds0, 8'h04);
        dir[0] = 1'b1;
        run(0, 14);
        dir[0] = 1'b0;

        // Bar, switched to ring at PH=5
        mode[0] = 2'b11;
        run(0, 1);
        for (int i = 0; i < 40 && !(m_ph[0] == 5 && m_pc[0] == 1); i++) cycle(0);
        #1 check("bar_ph5", leds0, 8'h3F);
        mode[0] = 2'b10;
        run(0, 1);
        #1 check("switch_ring", leds0, 8'h01);
        run(0, 6);

        // Pause at PC=2
        for (int i = 0; i < 8 && m_pc[0] != 2; i++) cycle(0);
        en[0] = 1'b0;
        run(0, 10);
        en[0] = 1'b1;
        run(0, 6);

        // Asynchronous reset between clock edges
        mode[0] = 2'b00;
        run(0, 11);
        #2 rstn[0] = 1'b0;
        #1;
        check("async_leds", leds0, 8'h00);
        check("async_step", {7'b0, step0}, 8'h00);
        check("async_wrap", {7'b0, wrap0}, 8'h00);
        @(negedge clk);
        model_reset(0);
        run(0, 2);
        rstn[0] = 1'b1;
        run(0, 24);

        // WIDTH=2, PRESCALE=1
        run(1, 2);
        rstn[1] = 1'b1;
        mode[1] = 2'b10;
        run(1, 6);
        #1 check("w2_step_hi", {7'b0, step1}, 8'h01);
        mode[1] = 2'b00;
        run(1, 10);
        en[1] = 1'b0;
        run(1, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised LED pattern generator with a built-in step prescaler; it drives a WIDTH-bit LED bar directly from the board clock.
- Generalises the fixed 8-LED Johnson/bounce demo:
  - selectable WIDTH and step period;
  - four run-time patterns;
  - direction control;
  - pattern-wrap reporting.
- Sits at top level between the board clock/reset/switches and the LED pins.

Parameters:
- WIDTH, 8: number of LEDs; legal range is 2 or more.
- PRESCALE, 1250000: CLK cycles per pattern step; legal range is 1 or more.
- CW, $clog2(PRESCALE) (minimum 1): prescaler counter width (derived; do not override).
- PHW, $clog2(2*WIDTH): phase counter width (derived).

Ports:
- CLK  in  1  system clock; all state on the rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- ENABLE  in  1  run/pause. High runs the prescaler and advances the pattern; low freezes all state.
- MODE  in  2  pattern select: 00 JOHNSON, 01 BOUNCE, 10 RING, 11 BAR.
- DIR  in  1  0 = phase counts up, 1 = phase counts down.
- LEDS  out  WIDTH  pattern output; bit 0 is the first LED.
- STEP  out  1  one-cycle pulse on each pattern advance.
- WRAP  out  1  one-cycle pulse when the phase wraps (end of the pattern period).

Behaviour:
- State registers:
  - PC: prescaler, range 0..PRESCALE-1.
  - PH: phase, range 0..P-1.
  - MODE_Q: registered copy of MODE.
- Reset (RSTn low, asynchronous):
  - PC=0, PH=0, MODE_Q=JOHNSON.
  - Outputs: LEDS=0, STEP=0, WRAP=0.
  - All outputs hold these values while RSTn is low.
- Pattern period P by MODE_Q: JOHNSON 2*WIDTH; BOUNCE 2*WIDTH-2; RING WIDTH; BAR WIDTH.
- Prescaler:
  - With ENABLE=1, PC increments each cycle and wraps from PRESCALE-1 to 0.
  - STEP = ENABLE && PC==PRESCALE-1 (combinational from registers and ENABLE).
  - With PRESCALE=1, STEP is high on every enabled cycle.
- Phase update on a STEP cycle:
  - DIR=0: PH <= (PH==P-1) ? 0 : PH+1.
  - DIR=1: PH <= (PH==0) ? P-1 : PH-1.
  - The new pattern is visible on LEDS one cycle after the STEP pulse.
- WRAP is high on a STEP cycle whose update performs a wrap (up: PH==P-1; down: PH==0).
- ENABLE=0:
  - PC, PH and LEDS hold.
  - STEP=0 and WRAP=0.
  - Pause mid-count resumes from the held PC; the prescaler is not restarted.
- Mode change:
  - MODE_Q <= MODE every cycle, regardless of ENABLE.
  - If MODE != MODE_Q, then on that edge PC <= 0 and PH <= 0, and any coincident step is discarded.
  - STEP and WRAP are forced low on that cycle.
  - The new pattern starts from phase 0 of the new period, so PH never exceeds P-1.
- DIR change takes effect on the next step. It causes no reset.
- LEDS decode is a pure function of registered PH and MODE_Q; there is no combinational path from input pins to LEDS.
  - JOHNSON:
    - PH < WIDTH: bits [PH-1:0]=1, all others 0 (PH=0 gives all zero).
    - PH >= WIDTH: with k=PH-WIDTH, bits [k-1:0]=0, all others 1.
    - This reproduces the twisted-ring sequence.
  - BOUNCE: one-hot at bit PH if PH < WIDTH, else at bit 2*WIDTH-2-PH. The end LEDs are lit once per sweep.
  - RING: one-hot at bit PH.
  - BAR: bits [PH:0]=1 (thermometer).
- Arithmetic is unsigned. PC and PH are compared against parameter-derived constants of matching width; there is no implicit truncation.

Decomposition:
- Package led_seq_pkg:
  - mode_t enum {JOHNSON, BOUNCE, RING, BAR} (2 bits).
  - function period(mode_t, WIDTH).
  - The LEDS decode function.
- Sub-module step_prescaler:
  - Parameter PRESCALE.
  - Ports CLK, RSTn, ENABLE, CLR, TC (TC = STEP).
  - This is the natural split; phase, decode and wrap logic stay in led_sequencer.

Test Plan (WIDTH=8, PRESCALE=4 unless stated):
- Reset, then ENABLE=1, MODE=00, DIR=0:
  - LEDS=0 after reset; STEP pulses every 4th cycle (first at cycle 4 after reset release).
  - LEDS steps 00000001, 00000011 … 11111111, 11111110 … 10000000, 00000000.
  - WRAP pulses on the 16th STEP.
- MODE=01:
  - LEDS walks 0x01..0x80, then 0x40..0x02, then 0x01 again.
  - Period is 14 steps; 0x80 and 0x01 are each held for exactly one step per sweep.
- MODE=10 with DIR toggling:
  - DIR=0: 0x01 → 0x02 → 0x04.
  - DIR=1 after 0x04: 0x02 → 0x01 → 0x80, with WRAP on the 0x01 → 0x80 step.
- MODE=11, with MODE switched to 10 mid-period at PH=5 (LEDS=0x3F):
  - Next cycle PH=0, LEDS=0x01, PC restarted.
  - No STEP/WRAP pulse on the switch cycle; next STEP occurs 4 cycles later.
- ENABLE dropped for 10 cycles at PC=2:
  - LEDS, PC and PH frozen; STEP=0.
  - After re-enable, STEP occurs exactly 2 cycles later.
- PRESCALE=1, WIDTH=2:
  - STEP is constantly high while enabled.
  - RING alternates 01/10 each cycle; JOHNSON sequence is 00, 01, 11, 10.
- RSTn asserted asynchronously mid-step (not aligned to CLK):
  - All outputs go to 0 immediately.
  - Restart behaves exactly as after power-on reset.
